uart_rx: RTL
============

# uart_rx

UART receive block: the receiving end of the 8N1 serial link driven by our transmitter. It synchronises the asynchronous `rs232_rx` line, qualifies the start bit, and mid-bit samples 8 data bits LSB-first plus one stop bit. It presents the byte on `rx_data` with a busy/complete flag, `rx_int`. `rx_int` falls once per received frame, so a downstream transmitter that captures on the falling edge of `rx_int` can loop received bytes straight back. Baud timing is generated internally; no external baud module is needed.

## Interface
- `CLK_DIV`, default 5208: clocks per bit period (50 MHz / 9600). Legal values are ≥ 8.
- `CNT_W`, default 13: width of the baud counter. Must satisfy 2^CNT_W > CLK_DIV.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high. This is the already-decided convention: one clock, synchronous active-high reset.
- `rs232_rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `rx_data`  out  8  last received byte; holds until the next frame completes.
- `rx_int`  out  1  high while a confirmed frame is being received; low when idle.
- `rx_valid`  out  1  one-cycle pulse for a frame with a good stop bit.
- `frame_err`  out  1  stop-bit status of the last completed frame.

## Operation
- **Synchroniser and edge detect**
  - Flops `s0` → `s1` → `s2` sample `rs232_rx`; all reset to 1.
  - `fall = s2 & ~s1`.
  - All sampling uses `s1`.
- **Baud counter `cnt`** (`CNT_W` bits): cleared on every state entry, otherwise increments by 1 each clock. `H = CLK_DIV/2`, integer division.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **IDLE**
  - On `fall`: go to START and clear `cnt`.
  - A line held low never retriggers; a new frame needs a high → low transition.
- **START**
  - When `cnt == H-1`, sample `s1`.
  - If `s1 = 0`: start bit confirmed. Go to DATA, clear `cnt` and `bit_idx`, set `rx_int` = 1.
  - If `s1 = 1`: glitch. Return to IDLE with no output change.
- **DATA**
  - When `cnt == CLK_DIV-1`, shift `s1` into bit 7 of `shift` (right shift, LSB-first on the wire) and increment the 3-bit `bit_idx`. Also clear `cnt`.
  - After the 8th sample (`bit_idx` was 7), go to STOP.
- **STOP**
  - When `cnt == CLK_DIV-1`, sample `s1`. In that same edge:
    - `rx_data <= shift`.
    - `rx_int <= 0`.
    - `frame_err <= ~s1`.
    - `rx_valid <= s1`.
    - Go to IDLE.
  - Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
- **`rx_valid`** is a single-cycle pulse; it is cleared on the following clock.
- **Frame error**
  - `rx_data` is still updated with the received bits and `rx_int` still falls.
  - `rx_valid` stays 0.
  - `frame_err` stays 1 until the next completed frame has a good stop bit.
- **Reset** (`rst` = 1 at a clock edge, including mid-frame):
  - State → IDLE; `cnt`, `bit_idx` and `shift` → 0; synchroniser flops → 1.
  - `rx_data` = 8'h00, `rx_int` = 0, `rx_valid` = 0, `frame_err` = 0.
  - Reset has priority over all other activity.

## Timing
- All outputs are registered; there are no combinational paths from the input.
- Pin-to-`fall` latency: 2 clocks (synchroniser).
- Start sample: H clocks after entering START.
- Data bit n (n = 0..7) sample: H + (n+1)·CLK_DIV clocks after START entry.
- Stop sample: H + 9·CLK_DIV clocks after START entry.
- `rx_int`:
  - Rises 1 clock after the start sample.
  - Falls in the same cycle that `rx_data`, `frame_err` and `rx_valid` update.
  - High for 9·CLK_DIV clocks.
- From the pin falling edge to the `rx_valid` pulse: 3 + H + 9·CLK_DIV clocks, ±1.
- Sampling is mid-bit. Tolerates about ±4% total baud mismatch.
- Minimum glitch that is rejected: any low pulse shorter than H clocks.

## Test plan
- **Reset:** assert `rst` for 3 cycles with the line high → `rx_data` = 0x00, `rx_int` = 0, `rx_valid` = 0, `frame_err` = 0 at every cycle during and after reset.
- **Single byte:** `CLK_DIV` = 16, send 0x55 (8N1, 16 clk/bit) → `rx_data` = 0x55, one `rx_valid` pulse, `frame_err` = 0, `rx_int` high for 144 clocks, and `rx_int` falls in the same cycle as `rx_valid`.
- **Back-to-back:** send 0xA5 then 0x3C with exactly one stop bit and no idle gap → two `rx_valid` pulses with `rx_data` 0xA5 then 0x3C, and two `rx_int` falling edges.
- **Glitch:** drive the line low for 4 clocks, then high (`CLK_DIV` = 16) → FSM returns to IDLE, `rx_int` never rises, no `rx_valid`.
- **Framing error:**
  - Send 0xF0 with the stop bit low, then hold the line low for 40 clocks → `rx_data` = 0xF0, `frame_err` = 1, no `rx_valid`, exactly one `rx_int` fall, and no new frame starts while the line stays low.
  - Release the line, then send a valid 0x81 → `rx_data` = 0x81, `rx_valid` pulses, `frame_err` = 0.
- **Reset mid-frame:** pulse `rst` during bit 4 of 0xC3 → `rx_int` = 0 the next cycle, no `rx_valid`, `rx_data` = 0x00. A following clean 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, qualifies the start bit at
// mid-bit, samples 8 data bits LSB-first plus the stop bit, and flags the frame.
module uart_rx #(
  parameter int CLK_DIV = 5208,
  parameter int CNT_W   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_int_q, rx_int_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             fall, half_hit, full_hit;

  assign fall     = s2_q & ~s1_q;
  assign half_hit = (cnt_q == HALF_M1);
  assign full_hit = (cnt_q == FULL_M1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (half_hit) state_d = s1_q ? IDLE : DATA;
      DATA:    if (full_hit && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (full_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_d        = rs232_rx;
    s1_d        = s0_q;
    s2_d        = s1_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_int_d    = rx_int_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    // The bit timer restarts on every state entry so each phase counts from zero.
    if (state_d != state_q) cnt_d = '0;
    case (state_q)
      START: begin
        if (half_hit && !s1_q) begin
          bit_idx_d = '0;
          rx_int_d  = 1'b1;
        end
      end
      DATA: begin
        if (full_hit) begin
          cnt_d     = '0;
          shift_d   = {s1_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (full_hit) begin
          rx_data_d   = shift_q;
          rx_int_d    = 1'b0;
          frame_err_d = ~s1_q;
          rx_valid_d  = s1_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_int_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_int_q    <= rx_int_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_int    = rx_int_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
